// File: rtl/conv_encoder_213_pkg.sv
// ---------------------------------------------------------------------------
// conv_encoder_213_pkg
//   Shared constants for the (2,1,3) convolutional code: code dimensions,
//   tail length, default generator polynomials, the encoder FSM state type
//   and the tap-parity helper used to form each code bit.
//   The matching Viterbi decoder derives its expected-symbol tables from the
//   same G0/G1 defaults, so these must stay in step with it.
// ---------------------------------------------------------------------------
package conv_encoder_213_pkg;

  // One input bit per step, two code bits out, three bits of memory.
  localparam int K = 1;
  localparam int N = 2;
  localparam int M = 3;

  // Shift-register width and number of zero tail bits that flush it.
  localparam int SR_W     = M * K;
  localparam int TAIL_LEN = M;

  // Default generators. MSB taps the current input, LSB the oldest state bit.
  localparam logic [M:0] G0_DEFAULT = 4'b1111;
  localparam logic [M:0] G1_DEFAULT = 4'b1101;

  // Encoder frame FSM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  // One code bit: XOR of the window bits selected by the generator taps.
  function automatic logic tap_parity(input logic [M:0] gen, input logic [M:0] window);
    return ^(gen & window);
  endfunction

endpackage

// File: rtl/conv_encoder_213_core.sv
// ---------------------------------------------------------------------------
// conv_enc_core_213
//   Encoder datapath: the three-bit shift register holding past inputs and the
//   two generator parities computed over the window {u, sr}. The symbol is
//   purely combinational from u and the current register; the register only
//   advances when load is high, so the caller decides when a bit is consumed.
//
//   Ports
//     clock  in   1  rising-edge clock
//     reset  in   1  synchronous, active-high; clears the shift register
//     load   in   1  shift u into the register this cycle
//     u      in   1  input bit for the current step (0 during the tail)
//     sym    out  2  {c0 (G0), c1 (G1)} for window {u, sr}
// ---------------------------------------------------------------------------
module conv_enc_core_213
  import conv_encoder_213_pkg::*;
#(
  parameter logic [M:0] G0 = G0_DEFAULT,
  parameter logic [M:0] G1 = G1_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         u,
  output logic [N-1:0] sym
);

  // sr[SR_W-1] is the most recent past input, sr[0] the oldest.
  logic [SR_W-1:0] sr;
  logic [M:0]      window;

  assign window = {u, sr};
  assign sym    = {tap_parity(G0, window), tap_parity(G1, window)};

  // New bit enters at the top; the oldest bit falls off the bottom.
  always_ff @(posedge clock) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= {u, sr[SR_W-1:1]};
    end
  end

endmodule

// File: rtl/conv_encoder_213.sv
// ---------------------------------------------------------------------------
// conv_encoder_213
//   Rate-1/2, memory-3 convolutional encoder. Takes information bits on a
//   valid/ready stream, groups them into frames of FRAME_LEN bits (or fewer
//   when flush marks an early last bit), appends three zero tail bits so each
//   frame ends in state 0, and emits one two-bit code symbol per encoded bit
//   through a single output register with valid/ready handshaking.
//
//   Ports
//     clock      in   1  rising-edge clock
//     reset      in   1  synchronous, active-high
//     din        in   1  information bit
//     din_valid  in   1  din is presented
//     din_ready  out  1  encoder accepts din this cycle
//     flush      in   1  with a din handshake: this bit ends the frame
//     tx         out  2  code symbol {c0 (G0), c1 (G1)}, decoder Rx[1:0] order
//     tx_valid   out  1  tx holds a valid symbol
//     tx_ready   in   1  downstream consumes tx this cycle
//     tx_sof     out  1  tx is the first symbol of a frame
//     tx_eof     out  1  tx is the last tail symbol of a frame
//     busy       out  1  a frame is in progress (state != IDLE)
// ---------------------------------------------------------------------------
module conv_encoder_213
  import conv_encoder_213_pkg::*;
#(
  parameter int         FRAME_LEN = 64,
  parameter logic [M:0] G0        = G0_DEFAULT,
  parameter logic [M:0] G1        = G1_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         flush,
  output logic [N-1:0] tx,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_sof,
  output logic         tx_eof,
  output logic         busy
);

  localparam int                CNT_W            = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  FRAME_LAST       = CNT_W'(FRAME_LEN);
  localparam bit                SINGLE_BIT_FRAME = (FRAME_LEN == 1);
  localparam int                TCNT_W           = $clog2(TAIL_LEN + 1);
  localparam logic [TCNT_W-1:0] TAIL_LAST        = TCNT_W'(TAIL_LEN - 1);

  enc_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [TCNT_W-1:0] tcnt;

  logic         adv;
  logic         in_hs;
  logic         tail_load;
  logic         last_tail;
  logic         core_load;
  logic         core_u;
  logic [N-1:0] core_sym;

  // The output register may take a new symbol whenever it is empty or its
  // current symbol is being consumed this cycle.
  assign adv = !tx_valid || tx_ready;

  // Input is accepted only outside the tail, only when the symbol it produces
  // has somewhere to go, and never while reset is asserted.
  assign din_ready = !reset && adv && (state != TAIL);
  assign in_hs     = din_valid && din_ready;

  // Tail steps push zeros through the encoder whenever the output can advance;
  // the last of them closes the frame.
  assign tail_load = (state == TAIL) && adv;
  assign last_tail = tail_load && (tcnt == TAIL_LAST);

  // A data handshake and a tail step are mutually exclusive (din_ready is low
  // in TAIL), so the encoder input is simply din or a forced zero.
  assign core_load = in_hs || tail_load;
  assign core_u    = (state == TAIL) ? 1'b0 : din;
  assign cnt_inc   = cnt + 1'b1;

  assign busy = (state != IDLE);

  conv_enc_core_213 #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .load  (core_load),
    .u     (core_u),
    .sym   (core_sym)
  );

  // Output register: loads only when it can advance. A cycle that advances
  // without a new symbol empties the register and clears the frame markers,
  // leaving the stale tx value in place.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx       <= '0;
      tx_valid <= 1'b0;
      tx_sof   <= 1'b0;
      tx_eof   <= 1'b0;
    end else if (adv) begin
      tx_valid <= core_load;
      tx_sof   <= in_hs && (state == IDLE);
      tx_eof   <= last_tail;
      if (core_load) begin
        tx <= core_sym;
      end
    end
  end

  // Frame FSM with the data and tail counters. The end-of-data decision takes
  // flush and the length limit together, so a flushed bit that also fills the
  // frame still enters the tail exactly once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_hs) begin
            cnt  <= CNT_W'(1);
            tcnt <= '0;
            if (flush || SINGLE_BIT_FRAME) begin
              state <= TAIL;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (in_hs) begin
            cnt <= cnt_inc;
            if (flush || (cnt_inc == FRAME_LAST)) begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          if (tail_load) begin
            if (last_tail) begin
              state <= IDLE;
              tcnt  <= '0;
              cnt   <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_213.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder_213
//   Self-checking bench for conv_encoder_213. Two instances share the input
//   drive: dut_a with FRAME_LEN=64 and dut_b with FRAME_LEN=1. A cycle table
//   covers reset, impulse, linearity, reset-mid-tail and stall behaviour;
//   randomized streams on dut_a are checked against a convolution model.
// ---------------------------------------------------------------------------
module tb_conv_encoder_213;

  localparam logic [3:0] REF_G0 = 4'b1111;
  localparam logic [3:0] REF_G1 = 4'b1101;
  localparam int         REF_FRAME = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset     = 1'b1;
  logic din       = 1'b0;
  logic din_valid = 1'b0;
  logic flush     = 1'b0;
  logic tx_ready  = 1'b1;
  logic sel_b     = 1'b0;

  logic       din_ready_a, tx_valid_a, tx_sof_a, tx_eof_a, busy_a;
  logic [1:0] tx_a;
  logic       din_ready_b, tx_valid_b, tx_sof_b, tx_eof_b, busy_b;
  logic [1:0] tx_b;

  logic       din_ready_m, tx_valid_m, tx_sof_m, tx_eof_m, busy_m;
  logic [1:0] tx_m;

  conv_encoder_213 #(.FRAME_LEN(64)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_a),
    .flush     (flush),
    .tx        (tx_a),
    .tx_valid  (tx_valid_a),
    .tx_ready  (tx_ready),
    .tx_sof    (tx_sof_a),
    .tx_eof    (tx_eof_a),
    .busy      (busy_a)
  );

  conv_encoder_213 #(.FRAME_LEN(1)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready_b),
    .flush     (flush),
    .tx        (tx_b),
    .tx_valid  (tx_valid_b),
    .tx_ready  (tx_ready),
    .tx_sof    (tx_sof_b),
    .tx_eof    (tx_eof_b),
    .busy      (busy_b)
  );

  // Table vectors look at whichever instance the vector selects.
  always_comb begin
    din_ready_m = sel_b ? din_ready_b : din_ready_a;
    tx_valid_m  = sel_b ? tx_valid_b  : tx_valid_a;
    tx_sof_m    = sel_b ? tx_sof_b    : tx_sof_a;
    tx_eof_m    = sel_b ? tx_eof_b    : tx_eof_a;
    busy_m      = sel_b ? busy_b      : busy_a;
    tx_m        = sel_b ? tx_b        : tx_a;
  end

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b at %0t", name, actual, required, $time);
    end
  endtask

  // ---------------- table-driven cycle vectors ----------------
  typedef struct {
    logic       sel_b, rst, dv, d, fl, rdy;
    logic       e_valid;
    logic [1:0] e_tx;
    logic       e_sof, e_eof, e_ready, e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input vec_t v);
    sel_b     = v.sel_b;
    reset     = v.rst;
    din_valid = v.dv;
    din       = v.d;
    flush     = v.fl;
    tx_ready  = v.rdy;
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- stream reference model ----------------
  typedef struct packed {
    logic [1:0] tx;
    logic       sof;
    logic       eof;
  } sym_t;

  sym_t exp_q[$];
  bit   stim_bits[$];
  bit   stim_flush[$];
  int   hs_cycle[$];
  int   sym_seen, sof_seen, eof_seen;
  logic mon_en = 1'b0;

  // Code symbol i of a frame is the convolution of the (zero-extended) bit
  // sequence with each generator: tap j weights the input j steps back.
  task automatic modelFrame(input bit bits[$]);
    int len = bits.size();
    for (int i = 0; i < len + 3; i++) begin
      sym_t s;
      logic c0 = 1'b0;
      logic c1 = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if ((i - j >= 0) && (i - j < len) && bits[i - j]) begin
          c0 ^= REF_G0[3 - j];
          c1 ^= REF_G1[3 - j];
        end
      end
      s.tx  = {c0, c1};
      s.sof = (i == 0);
      s.eof = (i == len + 2);
      exp_q.push_back(s);
    end
  endtask

  task automatic planStream();
    bit cur[$];
    for (int i = 0; i < stim_bits.size(); i++) begin
      cur.push_back(stim_bits[i]);
      if (stim_flush[i] || cur.size() == REF_FRAME) begin
        modelFrame(cur);
        cur.delete();
      end
    end
  endtask

  task automatic doReset();
    reset     = 1'b1;
    din_valid = 1'b0;
    flush     = 1'b0;
    tx_ready  = 1'b1;
    sel_b     = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    stim_bits.delete();
    stim_flush.delete();
    hs_cycle.delete();
    sym_seen = 0;
    sof_seen = 0;
    eof_seen = 0;
  endtask

  // Drives the planned bits on dut_a with random gaps and backpressure until
  // every expected symbol has been consumed or the cycle budget runs out.
  task automatic runStream(input int valid_pct, input int ready_pct, input int max_cycles);
    int  idx = 0;
    int  cyc = 0;
    bit  hs;
    planStream();
    @(posedge clock);
    #1 mon_en = 1'b1;
    while ((idx < stim_bits.size() || exp_q.size() > 0) && cyc < max_cycles) begin
      din_valid = (idx < stim_bits.size()) && ($urandom_range(99) < valid_pct);
      din       = (idx < stim_bits.size()) ? stim_bits[idx] : 1'b0;
      flush     = (idx < stim_bits.size()) ? stim_flush[idx] : 1'b0;
      tx_ready  = ($urandom_range(99) < ready_pct);
      @(negedge clock);
      hs = din_valid && din_ready_a;
      @(posedge clock);
      #1;
      if (hs) begin
        hs_cycle.push_back(cyc);
        idx++;
      end
      cyc++;
    end
    mon_en    = 1'b0;
    din_valid = 1'b0;
    flush     = 1'b0;
    tx_ready  = 1'b1;
    checks++;
    if (cyc >= max_cycles) begin
      failures++;
      $display("[TB] FAIL stream_timeout actual=%0d cycles required<%0d pending=%0d", cyc, max_cycles, exp_q.size());
    end
  endtask

  // Stream monitor on dut_a: symbol order, stall stability and the
  // no-accept-while-stalled rule.
  logic [1:0] prev_tx;
  logic       prev_sof, prev_eof;
  logic       prev_stall = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (prev_stall) begin
        checkOutput("stall_valid", {7'd0, tx_valid_a}, 8'd1);
        checkOutput("stall_tx", {6'd0, tx_a}, {6'd0, prev_tx});
        checkOutput("stall_sof", {7'd0, tx_sof_a}, {7'd0, prev_sof});
        checkOutput("stall_eof", {7'd0, tx_eof_a}, {7'd0, prev_eof});
      end
      if (tx_valid_a && !tx_ready) begin
        checkOutput("ready_while_stalled", {7'd0, din_ready_a}, 8'd0);
      end
      if (tx_valid_a && tx_ready) begin
        sym_seen++;
        if (tx_sof_a) sof_seen++;
        if (tx_eof_a) eof_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_symbol actual=%b required=none", tx_a);
        end else begin
          sym_t e;
          e = exp_q.pop_front();
          checkOutput("stream_tx", {6'd0, tx_a}, {6'd0, e.tx});
          checkOutput("stream_sof", {7'd0, tx_sof_a}, {7'd0, e.sof});
          checkOutput("stream_eof", {7'd0, tx_eof_a}, {7'd0, e.eof});
        end
      end
      prev_stall = tx_valid_a && !tx_ready;
      prev_tx    = tx_a;
      prev_sof   = tx_sof_a;
      prev_eof   = tx_eof_a;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // sel_b, rst, dv, d, fl, rdy | valid, tx, sof, eof, din_ready, busy
    // Impulse on the FRAME_LEN=1 instance.
    vecs.push_back('{1,1,0,0,0,1, 0,2'b00,0,0,0,0});
    vecs.push_back('{1,0,0,0,0,1, 0,2'b00,0,0,1,0});
    vecs.push_back('{1,0,1,1,0,1, 1,2'b11,1,0,0,1});
    vecs.push_back('{1,0,0,0,0,1, 1,2'b11,0,0,0,1});
    vecs.push_back('{1,0,0,0,0,1, 1,2'b10,0,0,0,1});
    vecs.push_back('{1,0,0,0,0,1, 1,2'b11,0,1,1,0});
    vecs.push_back('{1,0,0,0,0,1, 0,2'b00,0,0,1,0});
    // Linearity (two ones, flushed) on the FRAME_LEN=64 instance.
    vecs.push_back('{0,1,0,0,0,1, 0,2'b00,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,1, 0,2'b00,0,0,1,0});
    vecs.push_back('{0,0,1,1,0,1, 1,2'b11,1,0,1,1});
    vecs.push_back('{0,0,1,1,1,1, 1,2'b00,0,0,0,1});
    vecs.push_back('{0,0,0,0,0,1, 1,2'b01,0,0,0,1});
    vecs.push_back('{0,0,0,0,0,1, 1,2'b01,0,0,0,1});
    vecs.push_back('{0,0,0,0,0,1, 1,2'b11,0,1,1,0});
    // Next frame straight after eof, then reset after the first tail symbol.
    vecs.push_back('{0,0,1,1,1,1, 1,2'b11,1,0,0,1});
    vecs.push_back('{0,0,0,0,0,1, 1,2'b11,0,0,0,1});
    vecs.push_back('{0,1,0,0,0,1, 0,2'b00,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,1, 0,2'b00,0,0,1,0});
    vecs.push_back('{0,0,1,1,1,1, 1,2'b11,1,0,0,1});
    vecs.push_back('{0,0,0,0,0,1, 1,2'b11,0,0,0,1});
    vecs.push_back('{0,0,0,0,0,1, 1,2'b10,0,0,0,1});
    vecs.push_back('{0,0,0,0,0,1, 1,2'b11,0,1,1,0});
    vecs.push_back('{0,0,0,0,0,1, 0,2'b00,0,0,1,0});
    // Stall: symbol held while tx_ready is low, then a partial frame reset away.
    vecs.push_back('{0,0,1,1,0,0, 1,2'b11,1,0,0,1});
    vecs.push_back('{0,0,1,0,0,0, 1,2'b11,1,0,0,1});
    vecs.push_back('{0,0,1,0,0,1, 1,2'b11,0,0,1,1});
    vecs.push_back('{0,1,0,0,0,1, 0,2'b00,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,1, 0,2'b00,0,0,1,0});

    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_valid", i), {7'd0, tx_valid_m}, {7'd0, vecs[i].e_valid});
      checkOutput($sformatf("v%0d_din_ready", i), {7'd0, din_ready_m}, {7'd0, vecs[i].e_ready});
      checkOutput($sformatf("v%0d_busy", i), {7'd0, busy_m}, {7'd0, vecs[i].e_busy});
      if (vecs[i].e_valid || vecs[i].rst) begin
        checkOutput($sformatf("v%0d_tx", i), {6'd0, tx_m}, {6'd0, vecs[i].e_tx});
        checkOutput($sformatf("v%0d_sof", i), {7'd0, tx_sof_m}, {7'd0, vecs[i].e_sof});
        checkOutput($sformatf("v%0d_eof", i), {7'd0, tx_eof_m}, {7'd0, vecs[i].e_eof});
      end
    end

    // All-zero full frame followed back-to-back by a random full frame.
    doReset();
    for (int i = 0; i < 2 * REF_FRAME; i++) begin
      stim_bits.push_back((i < REF_FRAME) ? 1'b0 : 1'($urandom_range(1)));
      stim_flush.push_back(1'b0);
    end
    runStream(100, 100, 400);
    checkOutput("zero_symbols", 8'(sym_seen), 8'(2 * (REF_FRAME + 3)));
    checkOutput("zero_sof_count", 8'(sof_seen), 8'd2);
    checkOutput("zero_eof_count", 8'(eof_seen), 8'd2);
    if (hs_cycle.size() > REF_FRAME)
      checkOutput("back_to_back_gap", 8'(hs_cycle[REF_FRAME] - hs_cycle[0]), 8'(REF_FRAME + 3));
    else
      checkOutput("back_to_back_hs", 8'(hs_cycle.size()), 8'(2 * REF_FRAME));

    // Random bits with random input gaps and 50% backpressure.
    doReset();
    for (int i = 0; i < REF_FRAME; i++) begin
      stim_bits.push_back(1'($urandom_range(1)));
      stim_flush.push_back(1'b0);
    end
    runStream(60, 50, 2000);
    checkOutput("bp_symbols", 8'(sym_seen), 8'(REF_FRAME + 3));
    checkOutput("bp_eof_count", 8'(eof_seen), 8'd1);

    // Early flush on the 5th bit, then a full random frame.
    doReset();
    for (int i = 0; i < 5 + REF_FRAME; i++) begin
      stim_bits.push_back(1'($urandom_range(1)));
      stim_flush.push_back(i == 4);
    end
    runStream(100, 100, 400);
    checkOutput("flush_symbols", 8'(sym_seen), 8'(8 + REF_FRAME + 3));
    checkOutput("flush_sof_count", 8'(sof_seen), 8'd2);
    @(negedge clock);
    checkOutput("flush_idle_busy", {7'd0, busy_a}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
